// File: rtl/data_mem_responder_if.sv
// Request/response bus between a requester and data_mem_responder.
// The requester drives the request and the responder drives the read response and Ready.
interface data_mem_responder_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  Enable;
    logic                  ReadWrite;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] DataIn;
    logic [DATA_WIDTH-1:0] DataOut;
    logic                  Ready;
    logic                  DataValid;

    modport master (
        output Enable, ReadWrite, Address, DataIn,
        input  DataOut, Ready, DataValid
    );

    modport slave (
        input  Enable, ReadWrite, Address, DataIn,
        output DataOut, Ready, DataValid
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port data memory. After reset it zero-fills every location once, then serves
// single-cycle writes and two-edge registered reads.
module data_mem_responder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        READ = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ready;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic accept_c;
    logic wr_c;
    logic rd_c;

    // A request is taken only while the registered Ready is high.
    assign accept_c = (state == IDLE) && ready && bus.Enable;
    assign wr_c     = accept_c && bus.ReadWrite;
    assign rd_c     = accept_c && !bus.ReadWrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            clr_cnt    <= '0;
            rd_addr    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            ready      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            unique case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
                    if (clr_cnt == CNT_LAST) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
                IDLE: begin
                    if (rd_c) begin
                        rd_addr <= bus.Address;
                        state   <= READ;
                        ready   <= 1'b0;
                    end
                end
                READ: begin
                    data_out   <= mem[rd_addr];
                    data_valid <= 1'b1;
                    state      <= IDLE;
                    ready      <= 1'b1;
                end
                default: begin
                    state   <= INIT;
                    clr_cnt <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: cleared one word per cycle during INIT, otherwise written by accepted writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[clr_cnt] <= '0;
            end else if (wr_c) begin
                mem[bus.Address] <= bus.DataIn;
            end
        end
    end

    assign bus.DataOut   = data_out;
    assign bus.Ready     = ready;
    assign bus.DataValid = data_valid;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: init timing, write/read paths, read isolation,
// reset during READ and INIT, and back-to-back read throughput.
module tb_data_mem_responder;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 10;

    logic clk;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    data_mem_responder_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    data_mem_responder #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles until Ready rises after the last reset edge; any DataValid is an error.
    task automatic count_init(input string tag);
        int n;
        bit dv_seen;
        n = 0;
        dv_seen = 1'b0;
        while (bus.Ready !== 1'b1 && n < 2000) begin
            tick();
            n++;
            if (bus.DataValid !== 1'b0) dv_seen = 1'b1;
        end
        check({tag, "_cycles"}, 32'(n), 32'd1024);
        check({tag, "_no_dv"}, 32'(dv_seen), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (bus.Ready !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        if (bus.Ready !== 1'b1) check({tag, "_ready_timeout"}, 32'(bus.Ready), 32'd1);
    endtask

    task automatic wr(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        bus.Enable    = 1'b1;
        bus.ReadWrite = 1'b1;
        bus.Address   = a;
        bus.DataIn    = d;
        tick();
        bus.Enable    = 1'b0;
    endtask

    // Read: accept edge, then data with a one-cycle DataValid on the next edge, then held.
    task automatic rd(input string tag, input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] exp);
        wait_ready(tag);
        bus.Enable    = 1'b1;
        bus.ReadWrite = 1'b0;
        bus.Address   = a;
        tick();
        bus.Enable    = 1'b0;
        check({tag, "_rdy_low"}, 32'(bus.Ready), 32'd0);
        check({tag, "_dv_early"}, 32'(bus.DataValid), 32'd0);
        tick();
        check({tag, "_dv"}, 32'(bus.DataValid), 32'd1);
        check({tag, "_data"}, 32'(bus.DataOut), 32'(exp));
        tick();
        check({tag, "_dv_pulse"}, 32'(bus.DataValid), 32'd0);
        check({tag, "_data_hold"}, 32'(bus.DataOut), 32'(exp));
    endtask

    initial begin
        bit ready_ok;
        bit dv_quiet;

        reset         = 1'b1;
        bus.Enable    = 1'b0;
        bus.ReadWrite = 1'b0;
        bus.Address   = '0;
        bus.DataIn    = '0;
        repeat (3) tick();
        check("rst_ready", 32'(bus.Ready), 32'd0);
        check("rst_dv", 32'(bus.DataValid), 32'd0);
        check("rst_dout", 32'(bus.DataOut), 32'd0);

        reset = 1'b0;
        count_init("init1");
        rd("rd0_clear", 10'd0, 8'h00);
        rd("rd511_clear", 10'd511, 8'h00);
        rd("rd1023_clear", 10'd1023, 8'h00);

        // Full-depth write burst, one per cycle.
        ready_ok = 1'b1;
        dv_quiet = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            if (bus.Ready !== 1'b1) ready_ok = 1'b0;
            bus.Enable    = 1'b1;
            bus.ReadWrite = 1'b1;
            bus.Address   = ADDR_WIDTH'(i);
            bus.DataIn    = DATA_WIDTH'(15 + i);
            tick();
            if (bus.DataValid !== 1'b0) dv_quiet = 1'b0;
        end
        bus.Enable = 1'b0;
        check("burst_ready", 32'(ready_ok), 32'd1);
        check("burst_no_dv", 32'(dv_quiet), 32'd0 + 32'd1);
        check("burst_dout_kept", 32'(bus.DataOut), 32'd0);
        rd("rd0_burst", 10'd0, 8'd15);
        rd("rd1023_burst", 10'd1023, 8'd14);
        rd("rd100_burst", 10'd100, 8'd115);

        // Write followed immediately by read of the same address.
        wr(10'd7, 8'hA5);
        rd("raw7", 10'd7, 8'hA5);
        wr(10'd7, 8'h11);
        check("wr_keeps_dout", 32'(bus.DataOut), 32'hA5);
        check("wr_no_dv", 32'(bus.DataValid), 32'd0);

        // Address/Enable changes during READ do not disturb the read in progress.
        wr(10'd3, 8'h3C);
        wr(10'd4, 8'h4D);
        bus.Enable    = 1'b1;
        bus.ReadWrite = 1'b0;
        bus.Address   = 10'd3;
        tick();
        bus.Address   = 10'd4;
        check("iso_rdy_low", 32'(bus.Ready), 32'd0);
        tick();
        check("iso_dv", 32'(bus.DataValid), 32'd1);
        check("iso_data", 32'(bus.DataOut), 32'h3C);
        check("iso_rdy_back", 32'(bus.Ready), 32'd1);
        tick();
        check("iso_second_accept", 32'(bus.Ready), 32'd0);
        check("iso_second_dv_low", 32'(bus.DataValid), 32'd0);
        bus.Enable = 1'b0;
        tick();
        check("iso_second_dv", 32'(bus.DataValid), 32'd1);
        check("iso_second_data", 32'(bus.DataOut), 32'h4D);

        // Continuous reads: one every other cycle.
        tick();
        bus.Enable    = 1'b1;
        bus.ReadWrite = 1'b0;
        bus.Address   = 10'd0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("cont_ready_%0d", k), 32'(bus.Ready), 32'((k % 2) == 0));
            check($sformatf("cont_dv_%0d", k), 32'(bus.DataValid), 32'((k % 2) == 0));
        end
        check("cont_data", 32'(bus.DataOut), 32'd15);
        bus.Enable = 1'b0;
        tick();

        // Reset asserted while a read is in flight.
        bus.Enable    = 1'b1;
        bus.ReadWrite = 1'b0;
        bus.Address   = 10'd7;
        tick();
        check("rstrd_in_read", 32'(bus.Ready), 32'd0);
        reset      = 1'b1;
        bus.Enable = 1'b0;
        tick();
        reset = 1'b0;
        check("rstrd_dv", 32'(bus.DataValid), 32'd0);
        check("rstrd_dout", 32'(bus.DataOut), 32'd0);
        check("rstrd_ready", 32'(bus.Ready), 32'd0);
        count_init("init2");
        rd("rd7_cleared", 10'd7, 8'h00);
        rd("rd3_cleared", 10'd3, 8'h00);
        rd("rd1023_cleared", 10'd1023, 8'h00);

        // Reset in the middle of INIT restarts the full clear.
        wr(10'd9, 8'h99);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (500) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_init("init3");
        rd("rd9_cleared", 10'd9, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of DataIn/DataOut.
REQ-002 Parameter ADDR_WIDTH, default 10, SHALL set the address width; depth = 2**ADDR_WIDTH (1024 words).
REQ-003 clk  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be synchronous and active-high.
REQ-005 Enable  input  1  SHALL mark a request present this cycle.
REQ-006 ReadWrite  input  1  SHALL select the operation: 1 = write, 0 = read.
REQ-007 Address  input  ADDR_WIDTH  SHALL give the word address of the request.
REQ-008 DataIn  input  DATA_WIDTH  SHALL give the write data.
REQ-009 DataOut  output  DATA_WIDTH  SHALL carry read data, registered.
REQ-010 Ready  output  1  SHALL indicate that a request is accepted at the next rising edge.
REQ-011 DataValid  output  1  SHALL pulse for one cycle when DataOut holds fresh read data.

Function
REQ-012 FSM states SHALL be INIT, IDLE and READ.
REQ-013 Request accepted: only on an edge where Enable=1 and Ready=1; Enable with Ready=0 is ignored; requester holds the request until accepted.
REQ-014 INIT: internal clear counter 0..DEPTH-1, one location written with 0 per cycle; Ready=0 throughout.
REQ-015 INIT exit: edge writing location DEPTH-1 moves FSM to IDLE; Ready=1 in the following cycle; INIT lasts exactly DEPTH cycles.
REQ-016 IDLE: Ready=1.
REQ-017 Write accepted in IDLE: mem[Address] <= DataIn on the accepting edge; FSM stays IDLE; one write per cycle sustainable.
REQ-018 Read accepted in IDLE: Address latched; FSM -> READ; Ready=0 for the next cycle.
REQ-019 READ: next edge loads DataOut <= mem[latched address], sets DataValid=1 for exactly one cycle, returns FSM to IDLE.
REQ-020 Read latency: 2 edges from accepting edge to DataValid high; back-to-back reads at most one per 2 cycles.
REQ-021 Address, DataIn and Enable changes during READ SHALL NOT affect the read in progress.
REQ-022 DataOut holds its last read value until the next read completes; writes never change DataOut.
REQ-023 Write to address A accepted at edge N, read of A accepted at edge N+1: read returns the new data.
REQ-024 Address is used unmodified; all 2**ADDR_WIDTH locations reachable; no wrap or range error.

Reset
REQ-025 reset=1 at an edge: FSM -> INIT, clear counter -> 0, DataOut -> 0, DataValid -> 0, Ready -> 0.
REQ-026 reset dominates all requests at the same edge; the request is dropped.
REQ-027 reset during READ: read aborted; no DataValid pulse; DataOut = 0.
REQ-028 reset during INIT: clearing restarts at location 0.
REQ-029 Memory contents SHALL be zero after every completed INIT; no clearing other than INIT.

Verification
REQ-030 Reset, then hold Enable=0 -> Ready=0 for exactly 1024 cycles, then Ready=1; reads of addresses 0, 511, 1023 return 0.
REQ-031 Write DataIn=15..(15+1023 mod 256) to addresses 0..1023 on consecutive cycles, ReadWrite=1 -> Ready stays 1 throughout; read back address 0 returns 15 and address 1023 returns 14, each with DataValid 2 edges after acceptance.
REQ-032 Write 0xA5 to address 7, read address 7 on the next cycle -> DataOut=0xA5 with one-cycle DataValid; following cycle DataValid=0 and DataOut remains 0xA5.
REQ-033 Read address 3 (holding 0x3C), change Address to 4 and raise Enable during READ -> DataOut=0x3C; request to 4 accepted only after Ready returns to 1.
REQ-034 Assert reset in the READ cycle -> no DataValid pulse, DataOut=0, Ready=0 for 1024 cycles, previously written data cleared to 0.
REQ-035 Continuous read requests with Enable=1 -> DataValid high every other cycle; Ready alternates 1/0.
